// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main FSM controller for the shared multicycle datapath
// Owns the NZCV flags and the condition check that gates every architectural write.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_control,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  state_t     cur_state;
  state_t     nxt_state;
  logic [3:0] flags;
  logic       cond_ex;
  logic       in_exec;
  logic       wb_state;
  logic       rd_is_pc;

  logic [1:0] dec_alu;
  logic       cmd_known;
  logic       is_cmp;
  logic       is_arith;

  always_comb begin
    dec_alu   = ALU_ADD;
    cmd_known = 1'b1;
    is_cmp    = 1'b0;
    is_arith  = 1'b0;
    case (funct[4:1])
      4'b0100: is_arith = 1'b1;
      4'b0010: begin dec_alu = ALU_SUB; is_arith = 1'b1; end
      4'b0000: dec_alu = ALU_AND;
      4'b1100: dec_alu = ALU_ORR;
      4'b1010: begin dec_alu = ALU_SUB; is_arith = 1'b1; is_cmp = 1'b1; end
      default: cmd_known = 1'b0;
    endcase
  end

  // flags is {N,Z,C,V}
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = ~(flags[3] ^ flags[0]);
      4'b1011: cond_ex = flags[3] ^ flags[0];
      4'b1100: cond_ex = ~flags[2] & ~(flags[3] ^ flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] ^ flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign in_exec  = (cur_state == S_EXECR) || (cur_state == S_EXECI);
  assign wb_state = (cur_state == S_ALUWB) || (cur_state == S_MEMWB);
  assign rd_is_pc = (rd == 4'd15);

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   nxt_state = S_MEMADR;
          2'b00:   nxt_state = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   nxt_state = S_BRANCH;
          default: nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: nxt_state = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt_state = S_MEMWB;
      S_EXECR,
      S_EXECI:  nxt_state = (cmd_known && !is_cmp) ? S_ALUWB : S_FETCH;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Strobes are masked by rst_n so nothing fires while reset is held.
  always_comb begin
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    ir_write    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ir_write   = rst_n;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB:  result_src = 2'b01;
      S_MEMWR:  adr_src = 1'b1;
      S_EXECR:  alu_control = dec_alu;
      S_EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = dec_alu;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
      end
      default: ;
    endcase
  end

  assign pc_write  = rst_n & ((cur_state == S_FETCH)
                   | ((cur_state == S_BRANCH) & cond_ex)
                   | (wb_state & rd_is_pc & cond_ex));
  assign reg_write = rst_n & wb_state & ~rd_is_pc & cond_ex;
  assign mem_write = rst_n & (cur_state == S_MEMWR) & cond_ex;
  assign state     = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      flags     <= 4'b0000;
    end else begin
      cur_state <= nxt_state;
      // cond_ex above still sees the old flags, so the update is self-consistent.
      if (in_exec && cond_ex && cmd_known && (funct[0] || is_cmp)) begin
        flags[3:2] <= alu_flags[3:2];
        if (is_arith) flags[1:0] <= alu_flags[1:0];
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [3:0] rd = 4'd0;
  logic [3:0] cond = 4'b1110;
  logic [3:0] alu_flags = 4'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
  logic [1:0] alu_src_b, result_src, alu_control;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rd(rd), .cond(cond),
    .alu_flags(alu_flags), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       op;
    logic [5:0]       funct;
    logic [3:0]       rd;
    logic [3:0]       cond;
    logic [3:0]       af;
    logic [2:0]       n;
    logic [0:4][3:0]  st;
    logic [0:4]       pcw;
    logic [0:4]       rw;
    logic [0:4]       mw;
    logic [1:0]       alu;
  } vec_t;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic       adr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic [1:0] alu;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] o, logic [5:0] f, logic [3:0] r, logic [3:0] c,
                              logic [3:0] a, logic [2:0] n, logic [19:0] st,
                              logic [4:0] pcw, logic [4:0] rw, logic [4:0] mw, logic [1:0] alu);
    vec_t v;
    v.op = o; v.funct = f; v.rd = r; v.cond = c; v.af = a; v.n = n;
    v.st = st; v.pcw = pcw; v.rw = rw; v.mw = mw; v.alu = alu;
    return v;
  endfunction

  // Per-state selects as the datapath expects them.
  function automatic exp_t state_exp(logic [3:0] s, logic pcw, logic irw, logic rw,
                                     logic mw, logic [1:0] alu);
    exp_t e;
    e = '0;
    e.st = s; e.pcw = pcw; e.irw = irw; e.rw = rw; e.mw = mw; e.alu = alu;
    case (s)
      4'd0, 4'd1: begin e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; end
      4'd2:       e.srcb = 2'b01;
      4'd3, 4'd5: e.adr = 1'b1;
      4'd4:       e.res = 2'b01;
      4'd7:       e.srcb = 2'b01;
      4'd9:       begin e.srcb = 2'b01; e.res = 2'b10; end
      default:    ;
    endcase
    return e;
  endfunction

  task automatic check(input exp_t e, input string name);
    exp_t a;
    a = {state, pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
         alu_src_b, result_src, alu_control};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got st=%0d pcw=%b irw=%b rw=%b mw=%b adr=%b a=%b b=%b res=%b alu=%b, expected st=%0d pcw=%b irw=%b rw=%b mw=%b adr=%b a=%b b=%b res=%b alu=%b",
               name, a.st, a.pcw, a.irw, a.rw, a.mw, a.adr, a.srca, a.srcb, a.res, a.alu,
               e.st, e.pcw, e.irw, e.rw, e.mw, e.adr, e.srca, e.srcb, e.res, e.alu);
    end
  endtask

  // Called at a negedge with the DUT in FETCH.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    logic [3:0] s;
    op = v.op; funct = v.funct; rd = v.rd; cond = v.cond; alu_flags = v.af;
    for (int c = 0; c < int'(v.n); c++) begin
      s = v.st[c];
      sb.push_back(state_exp(s, v.pcw[c], s == 4'd0, v.rw[c], v.mw[c],
                             (s == 4'd6 || s == 4'd7) ? v.alu : 2'b00));
    end
    for (int c = 0; c < int'(v.n); c++) begin
      #1;
      e = sb.pop_front();
      check(e, $sformatf("vec%0d_cyc%0d", idx, c));
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    exp_t rexp;
    // cond: 1110 AL, 0000 EQ, 0001 NE; funct = {I, cmd, S/L}
    vecs.push_back(mk(2'b00, 6'b001000, 4'd3,  4'b1110, 4'b1111, 3'd4, {4'd0,4'd1,4'd6,4'd8,4'd0}, 5'b10000, 5'b00010, 5'b0, 2'b00)); // ADD
    vecs.push_back(mk(2'b01, 6'b011001, 4'd15, 4'b1110, 4'b0000, 3'd5, {4'd0,4'd1,4'd2,4'd3,4'd4}, 5'b10001, 5'b00000, 5'b0, 2'b00)); // LDR pc
    vecs.push_back(mk(2'b00, 6'b010101, 4'd0,  4'b1110, 4'b0100, 3'd3, {4'd0,4'd1,4'd6,4'd0,4'd0}, 5'b10000, 5'b0,     5'b0, 2'b01)); // CMP -> Z
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b0000, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10100, 5'b0,     5'b0, 2'b00)); // BEQ taken
    vecs.push_back(mk(2'b00, 6'b110101, 4'd0,  4'b1110, 4'b0000, 3'd3, {4'd0,4'd1,4'd7,4'd0,4'd0}, 5'b10000, 5'b0,     5'b0, 2'b01)); // CMP imm -> 0
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b0000, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10000, 5'b0,     5'b0, 2'b00)); // BEQ not
    vecs.push_back(mk(2'b00, 6'b001001, 4'd3,  4'b1110, 4'b0011, 3'd4, {4'd0,4'd1,4'd6,4'd8,4'd0}, 5'b10000, 5'b00010, 5'b0, 2'b00)); // ADDS -> 0011
    vecs.push_back(mk(2'b00, 6'b100001, 4'd4,  4'b1110, 4'b1000, 3'd4, {4'd0,4'd1,4'd7,4'd8,4'd0}, 5'b10000, 5'b00010, 5'b0, 2'b10)); // ANDS -> 1011
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b0110, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10100, 5'b0,     5'b0, 2'b00)); // BVS taken
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b0010, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10100, 5'b0,     5'b0, 2'b00)); // BCS taken
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b0000, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10000, 5'b0,     5'b0, 2'b00)); // BEQ not
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b1011, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10000, 5'b0,     5'b0, 2'b00)); // BLT not
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b1010, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10100, 5'b0,     5'b0, 2'b00)); // BGE taken
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b0100, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10100, 5'b0,     5'b0, 2'b00)); // BMI taken
    vecs.push_back(mk(2'b00, 6'b010101, 4'd0,  4'b1110, 4'b0100, 3'd3, {4'd0,4'd1,4'd6,4'd0,4'd0}, 5'b10000, 5'b0,     5'b0, 2'b01)); // CMP -> 0100
    vecs.push_back(mk(2'b01, 6'b011000, 4'd2,  4'b0001, 4'b0000, 3'd4, {4'd0,4'd1,4'd2,4'd5,4'd0}, 5'b10000, 5'b0,     5'b00000, 2'b00)); // STRNE fail
    vecs.push_back(mk(2'b01, 6'b011000, 4'd2,  4'b1110, 4'b0000, 3'd4, {4'd0,4'd1,4'd2,4'd5,4'd0}, 5'b10000, 5'b0,     5'b00010, 2'b00)); // STR
    vecs.push_back(mk(2'b00, 6'b001001, 4'd3,  4'b0001, 4'b0000, 3'd4, {4'd0,4'd1,4'd6,4'd8,4'd0}, 5'b10000, 5'b00000, 5'b0, 2'b00)); // ADDSNE fail
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b0000, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10100, 5'b0,     5'b0, 2'b00)); // BEQ taken
    vecs.push_back(mk(2'b00, 6'b000011, 4'd6,  4'b1110, 4'b0000, 3'd3, {4'd0,4'd1,4'd6,4'd0,4'd0}, 5'b10000, 5'b0,     5'b0, 2'b00)); // unknown cmd
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b0000, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10100, 5'b0,     5'b0, 2'b00)); // BEQ taken
    vecs.push_back(mk(2'b00, 6'b111000, 4'd15, 4'b1110, 4'b0000, 3'd4, {4'd0,4'd1,4'd7,4'd8,4'd0}, 5'b10010, 5'b00000, 5'b0, 2'b11)); // ORR pc
    vecs.push_back(mk(2'b10, 6'b000000, 4'd0,  4'b1111, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10000, 5'b0,     5'b0, 2'b00)); // cond 1111
    vecs.push_back(mk(2'b11, 6'b000000, 4'd0,  4'b1110, 4'b0000, 3'd2, {4'd0,4'd1,4'd0,4'd0,4'd0}, 5'b10000, 5'b0,     5'b0, 2'b00)); // undefined
    vecs.push_back(mk(2'b00, 6'b000100, 4'd5,  4'b1110, 4'b0000, 3'd4, {4'd0,4'd1,4'd6,4'd8,4'd0}, 5'b10000, 5'b00010, 5'b0, 2'b01)); // SUB
    vecs.push_back(mk(2'b01, 6'b011001, 4'd7,  4'b0000, 4'b0000, 3'd5, {4'd0,4'd1,4'd2,4'd3,4'd4}, 5'b10000, 5'b00001, 5'b0, 2'b00)); // LDREQ
    vecs.push_back(mk(2'b01, 6'b011001, 4'd7,  4'b0001, 4'b0000, 3'd5, {4'd0,4'd1,4'd2,4'd3,4'd4}, 5'b10000, 5'b00000, 5'b0, 2'b00)); // LDRNE fail

    rexp = state_exp(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    #1 check(rexp, "reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset during MEMWR abandons the store at once.
    run_vec(mk(2'b01, 6'b011000, 4'd2, 4'b1110, 4'b0000, 3'd3, {4'd0,4'd1,4'd2,4'd0,4'd0}, 5'b10000, 5'b0, 5'b0, 2'b00), 100);
    #1 check(state_exp(4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00), "memwr_before_reset");
    rst_n = 1'b0;
    #1 check(rexp, "memwr_reset_now");
    @(negedge clk);
    #1 check(rexp, "memwr_reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // Flags were cleared by reset: EQ fails, NE passes.
    run_vec(mk(2'b10, 6'b000000, 4'd0, 4'b0000, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10000, 5'b0, 5'b0, 2'b00), 101);
    run_vec(mk(2'b10, 6'b000000, 4'd0, 4'b0001, 4'b0000, 3'd3, {4'd0,4'd1,4'd9,4'd0,4'd0}, 5'b10100, 5'b0, 5'b0, 2'b00), 102);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
